// File: rtl/nvme_xxq_doorbell_rr.sv
// nvme_xxq_doorbell_rr: NVMe doorbell MMIO write generator.
// Watches every SQ tail / CQ head pointer and writes the matching doorbell
// register whenever a pointer differs from the value last written. Requesters
// are served round-robin, an optional holdoff coalesces bursts of pointer
// updates, and each queue can be masked by its enable bit.
module nvme_xxq_doorbell_rr #(
    parameter int sq_num_queues = 4,
    parameter int cq_num_queues = 4,
    parameter int sq_ptr_width  = 8,
    parameter int cq_ptr_width  = 8,
    parameter int holdoff_width = 8
) (
    input  logic                                  clk,
    input  logic                                  reset,
    input  logic                                  q_reset,
    input  logic [31:0]                           doorbell_start_addr,
    input  logic [3:0]                            doorbell_stride,
    input  logic [holdoff_width-1:0]              holdoff_cycles,
    input  logic [sq_num_queues-1:0]              sq_enable,
    input  logic [cq_num_queues-1:0]              cq_enable,
    input  logic [sq_num_queues*sq_ptr_width-1:0] sq_tail,
    input  logic [cq_num_queues*cq_ptr_width-1:0] cq_head,
    output logic                                  xxq_pcie_wrvalid,
    output logic [31:0]                           xxq_pcie_wraddr,
    output logic [15:0]                           xxq_pcie_wrdata,
    input  logic                                  pcie_xxq_wrack,
    output logic                                  db_idle,
    output logic [31:0]                           db_count
);

    // SQs occupy requester slots 0..sq_num_queues-1, CQs follow them.
    localparam int num_req = sq_num_queues + cq_num_queues;
    localparam int idx_w   = $clog2(num_req);
    localparam int cand_w  = idx_w + 1;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_HOLD,
        ST_ARB,
        ST_WRITE
    } state_e;

    state_e                   state_q, state_d;
    logic [holdoff_width-1:0] hold_cnt_q, hold_cnt_d;
    logic [idx_w-1:0]         rr_ptr_q, rr_ptr_d;
    logic [idx_w-1:0]         grant_idx_q, grant_idx_d;
    logic                     wrvalid_q, wrvalid_d;
    logic [31:0]              wraddr_q, wraddr_d;
    logic [15:0]              wrdata_q, wrdata_d;
    logic [31:0]              db_count_q, db_count_d;
    logic [sq_ptr_width-1:0]  sq_last_q [sq_num_queues];
    logic [sq_ptr_width-1:0]  sq_last_d [sq_num_queues];
    logic [cq_ptr_width-1:0]  cq_last_q [cq_num_queues];
    logic [cq_ptr_width-1:0]  cq_last_d [cq_num_queues];

    logic [15:0]              ptr_ext  [num_req];
    logic [15:0]              last_ext [num_req];
    logic [num_req-1:0]       enable_all;
    logic [num_req-1:0]       pending;
    logic                     arb_found;
    logic [idx_w-1:0]         arb_idx;
    logic [cand_w-1:0]        cand;

    // Byte offset of a requester's doorbell register, scaled by CAP.DSTRD.
    function automatic logic [31:0] db_offset(input logic [idx_w-1:0] r,
                                              input logic [3:0]       stride);
        logic [31:0] base;
        if (32'(r) < 32'(sq_num_queues)) begin
            base = 32'(r) << 3;
        end else begin
            base = ((32'(r) - 32'(sq_num_queues)) << 3) + 32'd4;
        end
        return base << stride;
    endfunction

    // Flatten SQ/CQ pointers and last-written values into one requester view.
    always_comb begin
        for (int i = 0; i < sq_num_queues; i++) begin
            ptr_ext[i]  = 16'(sq_tail[i*sq_ptr_width +: sq_ptr_width]);
            last_ext[i] = 16'(sq_last_q[i]);
        end
        for (int j = 0; j < cq_num_queues; j++) begin
            ptr_ext[sq_num_queues+j]  = 16'(cq_head[j*cq_ptr_width +: cq_ptr_width]);
            last_ext[sq_num_queues+j] = 16'(cq_last_q[j]);
        end
        enable_all = {cq_enable, sq_enable};
        for (int r = 0; r < num_req; r++) begin
            pending[r] = enable_all[r] && (ptr_ext[r] != last_ext[r]);
        end
    end

    // Round-robin search: first pending requester at or above rr_ptr, wrapping.
    always_comb begin
        arb_found = 1'b0;
        arb_idx   = '0;
        cand      = '0;
        for (int k = 0; k < num_req; k++) begin
            // NOTE: blocking '=' is correct here; cand is a scratch value
            // consumed within the same iteration, not a stored state.
            cand = {1'b0, rr_ptr_q} + cand_w'(k);
            if (cand >= cand_w'(num_req)) begin
                cand = cand - cand_w'(num_req);
            end
            if (!arb_found && pending[cand[idx_w-1:0]]) begin
                arb_found = 1'b1;
                arb_idx   = cand[idx_w-1:0];
            end
        end
    end

    // Next-state and datapath: holdoff, grant capture, write handshake.
    always_comb begin
        // NOTE: every _d starts as its _q so no path through the case
        // below leaves a variable unassigned (which would infer a latch).
        state_d     = state_q;
        hold_cnt_d  = hold_cnt_q;
        rr_ptr_d    = rr_ptr_q;
        grant_idx_d = grant_idx_q;
        wrvalid_d   = wrvalid_q;
        wraddr_d    = wraddr_q;
        wrdata_d    = wrdata_q;
        db_count_d  = db_count_q;
        sq_last_d   = sq_last_q;
        cq_last_d   = cq_last_q;

        case (state_q)
            ST_IDLE: begin
                if (!q_reset && (|pending)) begin
                    if (holdoff_cycles == '0) begin
                        state_d = ST_ARB;
                    end else begin
                        hold_cnt_d = holdoff_cycles;
                        state_d    = ST_HOLD;
                    end
                end
            end
            ST_HOLD: begin
                if (q_reset) begin
                    state_d = ST_IDLE;
                end else if (hold_cnt_q <= holdoff_width'(1)) begin
                    state_d = ST_ARB;
                end else begin
                    hold_cnt_d = hold_cnt_q - holdoff_width'(1);
                end
            end
            ST_ARB: begin
                if (q_reset || !arb_found) begin
                    state_d = ST_IDLE;
                end else begin
                    grant_idx_d = arb_idx;
                    wrvalid_d   = 1'b1;
                    wraddr_d    = doorbell_start_addr + db_offset(arb_idx, doorbell_stride);
                    wrdata_d    = ptr_ext[arb_idx];
                    state_d     = ST_WRITE;
                end
            end
            ST_WRITE: begin
                // An in-flight write always finishes, even under q_reset.
                if (pcie_xxq_wrack) begin
                    wrvalid_d  = 1'b0;
                    db_count_d = db_count_q + 32'd1;
                    rr_ptr_d   = (grant_idx_q == idx_w'(num_req - 1)) ?
                                 '0 : grant_idx_q + idx_w'(1);
                    for (int i = 0; i < sq_num_queues; i++) begin
                        if (grant_idx_q == idx_w'(i)) begin
                            sq_last_d[i] = wrdata_q[sq_ptr_width-1:0];
                        end
                    end
                    for (int j = 0; j < cq_num_queues; j++) begin
                        if (grant_idx_q == idx_w'(sq_num_queues + j)) begin
                            cq_last_d[j] = wrdata_q[cq_ptr_width-1:0];
                        end
                    end
                    state_d = ST_ARB;
                end
            end
            default: state_d = ST_IDLE;
        endcase

        // Queue-set reset wipes the last-written history every cycle it is high.
        if (q_reset) begin
            for (int i = 0; i < sq_num_queues; i++) sq_last_d[i] = '0;
            for (int j = 0; j < cq_num_queues; j++) cq_last_d[j] = '0;
        end
    end

    // State registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= ST_IDLE;
            hold_cnt_q  <= '0;
            rr_ptr_q    <= '0;
            grant_idx_q <= '0;
            wrvalid_q   <= 1'b0;
            wraddr_q    <= '0;
            wrdata_q    <= '0;
            db_count_q  <= '0;
            // NOTE: the last-written arrays are reset because their contents
            // decide whether a doorbell is owed; stale values would fire writes.
            for (int i = 0; i < sq_num_queues; i++) sq_last_q[i] <= '0;
            for (int j = 0; j < cq_num_queues; j++) cq_last_q[j] <= '0;
        end else begin
            state_q     <= state_d;
            hold_cnt_q  <= hold_cnt_d;
            rr_ptr_q    <= rr_ptr_d;
            grant_idx_q <= grant_idx_d;
            wrvalid_q   <= wrvalid_d;
            wraddr_q    <= wraddr_d;
            wrdata_q    <= wrdata_d;
            db_count_q  <= db_count_d;
            sq_last_q   <= sq_last_d;
            cq_last_q   <= cq_last_d;
        end
    end

    assign xxq_pcie_wrvalid = wrvalid_q;
    assign xxq_pcie_wraddr  = wraddr_q;
    assign xxq_pcie_wrdata  = wrdata_q;
    assign db_count         = db_count_q;
    assign db_idle          = (state_q == ST_IDLE) && !(|pending);

endmodule

// File: tb/tb_nvme_xxq_doorbell_rr.sv
// Directed testbench for nvme_xxq_doorbell_rr (4 SQ + 4 CQ, 8-bit pointers).
module tb_nvme_xxq_doorbell_rr;

    localparam int SQN = 4;
    localparam int CQN = 4;
    localparam int PW  = 8;
    localparam int HW  = 8;
    localparam logic [31:0] START = 32'h2000_1000;

    logic              clk = 1'b0;
    logic              reset;
    logic              q_reset;
    logic [31:0]       doorbell_start_addr;
    logic [3:0]        doorbell_stride;
    logic [HW-1:0]     holdoff_cycles;
    logic [SQN-1:0]    sq_enable;
    logic [CQN-1:0]    cq_enable;
    logic [SQN*PW-1:0] sq_tail;
    logic [CQN*PW-1:0] cq_head;
    logic              xxq_pcie_wrvalid;
    logic [31:0]       xxq_pcie_wraddr;
    logic [15:0]       xxq_pcie_wrdata;
    logic              pcie_xxq_wrack;
    logic              db_idle;
    logic [31:0]       db_count;

    int checks   = 0;
    int failures = 0;
    logic [31:0] exp_count = 0;

    nvme_xxq_doorbell_rr #(
        .sq_num_queues(SQN), .cq_num_queues(CQN),
        .sq_ptr_width(PW), .cq_ptr_width(PW), .holdoff_width(HW)
    ) dut (
        .clk(clk), .reset(reset), .q_reset(q_reset),
        .doorbell_start_addr(doorbell_start_addr),
        .doorbell_stride(doorbell_stride),
        .holdoff_cycles(holdoff_cycles),
        .sq_enable(sq_enable), .cq_enable(cq_enable),
        .sq_tail(sq_tail), .cq_head(cq_head),
        .xxq_pcie_wrvalid(xxq_pcie_wrvalid),
        .xxq_pcie_wraddr(xxq_pcie_wraddr),
        .xxq_pcie_wrdata(xxq_pcie_wrdata),
        .pcie_xxq_wrack(pcie_xxq_wrack),
        .db_idle(db_idle), .db_count(db_count)
    );

    always #5 clk = ~clk;

    // Advance one clock; inputs are driven and outputs sampled 1ns after the edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Wait (bounded) for a write request; optionally ack it at once.
    // lat = clock edges waited from the call until wrvalid was observed.
    task automatic take_write(input bit do_ack, output bit seen,
                              output logic [31:0] a, output logic [15:0] d,
                              output int lat);
        lat  = 0;
        seen = 1'b0;
        a    = 'x;
        d    = 'x;
        while (lat < 60 && !xxq_pcie_wrvalid) begin
            step();
            lat++;
        end
        if (xxq_pcie_wrvalid) begin
            seen = 1'b1;
            a    = xxq_pcie_wraddr;
            d    = xxq_pcie_wrdata;
            if (do_ack) begin
                pcie_xxq_wrack = 1'b1;
                step();
                pcie_xxq_wrack = 1'b0;
            end
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        q_reset = 1'b0;
        pcie_xxq_wrack = 1'b0;
        doorbell_start_addr = START;
        doorbell_stride = 4'd0;
        holdoff_cycles = '0;
        sq_enable = '1;
        cq_enable = '1;
        sq_tail = '0;
        cq_head = '0;
        repeat (3) step();
        reset = 1'b0;
        step();
        checks++; if (xxq_pcie_wrvalid !== 1'b0) begin failures++; $display("FAIL reset_wrvalid got=%b want=0", xxq_pcie_wrvalid); end
        checks++; if (xxq_pcie_wraddr !== 32'h0) begin failures++; $display("FAIL reset_wraddr got=%h want=0", xxq_pcie_wraddr); end
        checks++; if (xxq_pcie_wrdata !== 16'h0) begin failures++; $display("FAIL reset_wrdata got=%h want=0", xxq_pcie_wrdata); end
        checks++; if (db_count !== 32'd0) begin failures++; $display("FAIL reset_db_count got=%0d want=0", db_count); end
        checks++; if (db_idle !== 1'b1) begin failures++; $display("FAIL reset_db_idle got=%b want=1", db_idle); end
    endtask

    task automatic test_basic();
        bit seen; logic [31:0] a; logic [15:0] d; int lat;
        sq_tail[0*PW +: PW] = 8'd5;
        step();
        checks++; if (xxq_pcie_wrvalid !== 1'b0) begin failures++; $display("FAIL basic_early_valid got=%b want=0", xxq_pcie_wrvalid); end
        take_write(1'b1, seen, a, d, lat);
        exp_count++;
        checks++; if (!seen || lat != 1) begin failures++; $display("FAIL basic_latency seen=%0d edges=%0d want=2", seen, lat + 1); end
        checks++; if (a !== START) begin failures++; $display("FAIL basic_addr got=%h want=%h", a, START); end
        checks++; if (d !== 16'h0005) begin failures++; $display("FAIL basic_data got=%h want=0005", d); end
        checks++; if (xxq_pcie_wrvalid !== 1'b0) begin failures++; $display("FAIL basic_drop_valid got=%b want=0", xxq_pcie_wrvalid); end
        checks++; if (db_count !== exp_count) begin failures++; $display("FAIL basic_db_count got=%0d want=%0d", db_count, exp_count); end
        step();
        checks++; if (db_idle !== 1'b1) begin failures++; $display("FAIL basic_db_idle got=%b want=1", db_idle); end
        step();
    endtask

    task automatic test_stride_cq();
        bit seen; logic [31:0] a; logic [15:0] d; int lat;
        doorbell_stride = 4'd2;
        cq_head[2*PW +: PW] = 8'h3F;
        take_write(1'b1, seen, a, d, lat);
        exp_count++;
        checks++; if (!seen || a !== START + 32'h50) begin failures++; $display("FAIL stride_addr got=%h want=%h", a, START + 32'h50); end
        checks++; if (d !== 16'h003F) begin failures++; $display("FAIL stride_data got=%h want=003f", d); end
        doorbell_stride = 4'd0;
        repeat (2) step();
    endtask

    task automatic test_round_robin();
        bit seen; logic [31:0] a; logic [15:0] d; int lat;
        logic [31:0] ea1 [3] = '{START, START + 32'h8, START + 32'h4};
        logic [15:0] ed1 [3] = '{16'd6, 16'd1, 16'd1};
        logic [31:0] ea2 [2] = '{START, START + 32'h4};
        logic [15:0] ed2 [2] = '{16'd7, 16'd2};
        // Fairness: SQ0 re-arms after its first grant; others still get their turn.
        logic [31:0] ea3 [5] = '{START + 32'hC, START + 32'h1C, START, START + 32'h18, START};
        logic [15:0] ed3 [5] = '{16'h11, 16'h33, 16'h08, 16'h44, 16'h09};
        // SQ0, SQ1 and CQ0 become pending together.
        sq_tail[0*PW +: PW] = 8'd6;
        sq_tail[1*PW +: PW] = 8'd1;
        cq_head[0*PW +: PW] = 8'd1;
        for (int i = 0; i < 3; i++) begin
            take_write(1'b1, seen, a, d, lat);
            exp_count++;
            checks++;
            if (!seen || a !== ea1[i] || d !== ed1[i] || lat != (i == 0 ? 2 : 1)) begin
                failures++;
                $display("FAIL rr_order1[%0d] addr=%h data=%h lat=%0d want addr=%h data=%h", i, a, d, lat, ea1[i], ed1[i]);
            end
        end
        repeat (2) step();
        sq_tail[0*PW +: PW] = 8'd7;
        cq_head[0*PW +: PW] = 8'd2;
        for (int i = 0; i < 2; i++) begin
            take_write(1'b1, seen, a, d, lat);
            exp_count++;
            checks++;
            if (!seen || a !== ea2[i] || d !== ed2[i]) begin
                failures++;
                $display("FAIL rr_order2[%0d] addr=%h data=%h want addr=%h data=%h", i, a, d, ea2[i], ed2[i]);
            end
        end
        repeat (2) step();
        sq_tail[0*PW +: PW] = 8'd8;
        sq_tail[3*PW +: PW] = 8'h44;
        cq_head[1*PW +: PW] = 8'h11;
        cq_head[3*PW +: PW] = 8'h33;
        for (int i = 0; i < 5; i++) begin
            take_write(1'b1, seen, a, d, lat);
            exp_count++;
            if (i == 2) sq_tail[0*PW +: PW] = 8'd9;
            checks++;
            if (!seen || a !== ea3[i] || d !== ed3[i]) begin
                failures++;
                $display("FAIL rr_fair[%0d] addr=%h data=%h want addr=%h data=%h", i, a, d, ea3[i], ed3[i]);
            end
        end
        repeat (2) step();
        checks++; if (db_count !== exp_count) begin failures++; $display("FAIL rr_db_count got=%0d want=%0d", db_count, exp_count); end
    endtask

    task automatic test_holdoff();
        bit seen; logic [31:0] a; logic [15:0] d; int lat;
        bit early = 1'b0;
        holdoff_cycles = 8'd10;
        sq_tail[3*PW +: PW] = 8'd1;
        for (int c = 1; c <= 6; c++) begin
            step();
            if (xxq_pcie_wrvalid) early = 1'b1;
            if (c == 3) sq_tail[3*PW +: PW] = 8'd2;
            if (c == 6) sq_tail[3*PW +: PW] = 8'd3;
        end
        take_write(1'b1, seen, a, d, lat);
        exp_count++;
        // IDLE edge + 10 HOLD cycles + ARB edge => valid 12 edges after the change.
        checks++; if (early || !seen || (6 + lat) != 12) begin failures++; $display("FAIL holdoff_latency edges=%0d early=%0d want=12", 6 + lat, early); end
        checks++; if (a !== START + 32'h18 || d !== 16'h0003) begin failures++; $display("FAIL holdoff_write addr=%h data=%h want addr=%h data=0003", a, d, START + 32'h18); end
        early = 1'b0;
        repeat (20) begin
            step();
            if (xxq_pcie_wrvalid) early = 1'b1;
        end
        checks++; if (early || db_count !== exp_count) begin failures++; $display("FAIL holdoff_single extra_write=%0d db_count=%0d want=%0d", early, db_count, exp_count); end
        holdoff_cycles = '0;
    endtask

    task automatic test_move_in_write();
        bit seen; logic [31:0] a; logic [15:0] d; int lat;
        bit unstable = 1'b0;
        sq_tail[2*PW +: PW] = 8'd7;
        take_write(1'b0, seen, a, d, lat);
        checks++; if (!seen || a !== START + 32'h10 || d !== 16'd7) begin failures++; $display("FAIL move_first addr=%h data=%h want addr=%h data=0007", a, d, START + 32'h10); end
        sq_tail[2*PW +: PW] = 8'd9;
        repeat (5) begin
            step();
            if (xxq_pcie_wrvalid !== 1'b1 || xxq_pcie_wraddr !== START + 32'h10 || xxq_pcie_wrdata !== 16'd7) unstable = 1'b1;
        end
        checks++; if (unstable) begin failures++; $display("FAIL move_stable valid=%b addr=%h data=%h want held 1/%h/0007", xxq_pcie_wrvalid, xxq_pcie_wraddr, xxq_pcie_wrdata, START + 32'h10); end
        pcie_xxq_wrack = 1'b1;
        step();
        pcie_xxq_wrack = 1'b0;
        exp_count++;
        take_write(1'b1, seen, a, d, lat);
        exp_count++;
        checks++; if (!seen || lat != 1 || d !== 16'd9) begin failures++; $display("FAIL move_second data=%h lat=%0d want data=0009 lat=1", d, lat); end
        repeat (2) step();
        checks++; if (db_count !== exp_count) begin failures++; $display("FAIL move_db_count got=%0d want=%0d", db_count, exp_count); end
    endtask

    task automatic test_qreset_enable();
        bit seen; logic [31:0] a; logic [15:0] d; int lat;
        logic [31:0] ea [7] = '{START + 32'h1C, START, START + 32'h10, START + 32'h18,
                                START + 32'h4, START + 32'hC, START + 32'h14};
        logic [15:0] ed [7] = '{16'h33, 16'h09, 16'h09, 16'h03, 16'h02, 16'h11, 16'h40};
        sq_enable[1] = 1'b0;
        cq_head[2*PW +: PW] = 8'h40;
        take_write(1'b0, seen, a, d, lat);
        checks++; if (!seen || a !== START + 32'h14 || d !== 16'h0040) begin failures++; $display("FAIL qrst_write addr=%h data=%h want addr=%h data=0040", a, d, START + 32'h14); end
        q_reset = 1'b1;
        pcie_xxq_wrack = 1'b1;
        step();
        q_reset = 1'b0;
        pcie_xxq_wrack = 1'b0;
        exp_count++;
        checks++; if (xxq_pcie_wrvalid !== 1'b0 || db_count !== exp_count) begin failures++; $display("FAIL qrst_complete valid=%b db_count=%0d want valid=0 db_count=%0d", xxq_pcie_wrvalid, db_count, exp_count); end
        // All history cleared: every enabled nonzero pointer re-issues, SQ1 stays masked.
        for (int i = 0; i < 7; i++) begin
            take_write(1'b1, seen, a, d, lat);
            exp_count++;
            checks++;
            if (!seen || a !== ea[i] || d !== ed[i]) begin
                failures++;
                $display("FAIL qrst_reissue[%0d] addr=%h data=%h want addr=%h data=%h", i, a, d, ea[i], ed[i]);
            end
        end
        repeat (4) step();
        checks++; if (xxq_pcie_wrvalid !== 1'b0 || db_idle !== 1'b1 || db_count !== exp_count) begin failures++; $display("FAIL qrst_masked valid=%b idle=%b db_count=%0d want 0/1/%0d", xxq_pcie_wrvalid, db_idle, db_count, exp_count); end
        sq_enable[1] = 1'b1;
        take_write(1'b1, seen, a, d, lat);
        exp_count++;
        checks++; if (!seen || a !== START + 32'h8 || d !== 16'h0001) begin failures++; $display("FAIL reenable addr=%h data=%h want addr=%h data=0001", a, d, START + 32'h8); end
        repeat (2) step();
    endtask

    task automatic test_revert_and_stray_ack();
        bit fired = 1'b0;
        holdoff_cycles = 8'd5;
        sq_tail[0*PW +: PW] = 8'd10;
        repeat (2) step();
        sq_tail[0*PW +: PW] = 8'd9;
        repeat (15) begin
            step();
            if (xxq_pcie_wrvalid) fired = 1'b1;
        end
        checks++; if (fired || db_count !== exp_count) begin failures++; $display("FAIL revert_no_write fired=%0d db_count=%0d want 0/%0d", fired, db_count, exp_count); end
        holdoff_cycles = '0;
        pcie_xxq_wrack = 1'b1;
        step();
        pcie_xxq_wrack = 1'b0;
        step();
        checks++; if (xxq_pcie_wrvalid !== 1'b0 || db_count !== exp_count) begin failures++; $display("FAIL stray_ack valid=%b db_count=%0d want 0/%0d", xxq_pcie_wrvalid, db_count, exp_count); end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog simulation time limit reached");
        $fatal(1);
    end

    initial begin
        test_reset();
        test_basic();
        test_stride_cq();
        test_round_robin();
        test_holdoff();
        test_move_in_write();
        test_qreset_enable();
        test_revert_and_stray_ack();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
